// File: rtl/hog_cell_vote_accumulator_pkg.sv
// Shared HOG constants and the segment FSM state type used by the
// cell vote accumulator and its vote-split pipeline.
package hog_cell_vote_accumulator_pkg;

    localparam int          NUM_BINS   = 9;
    localparam logic [10:0] BIN_SCALE  = 11'd1467;
    localparam int          ANGLE_FRAC = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } seg_state_t;

endpackage

// File: rtl/hog_cell_vote_accumulator_vote_split.sv
// Splits each gradient magnitude into a bottom-bin and a top-bin vote by
// linear interpolation on the fractional bin position of the folded angle.
module hog_cell_vote_accumulator_vote_split
    import hog_cell_vote_accumulator_pkg::*;
#(
    parameter int MAG_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de,
    input  logic [3:0]       bottom_bin,
    input  logic [3:0]       top_bin,
    input  logic [10:0]      angle,
    input  logic [MAG_W-1:0] magnitude,
    output logic             vote_vld,
    output logic [3:0]       vote_bottom_bin,
    output logic [3:0]       vote_top_bin,
    output logic [MAG_W-1:0] v_bot,
    output logic [MAG_W-1:0] v_top
);

    localparam int SCALED_W = 22;
    localparam int PROD_W   = MAG_W + ANGLE_FRAC;

    // Exactly nine bins means angle 180 deg, which folds back onto bin 0.
    function automatic logic [ANGLE_FRAC-1:0] interp_frac(input logic [SCALED_W-1:0] scaled);
        if (scaled[SCALED_W-1:2*ANGLE_FRAC] == 4'(NUM_BINS))
            return '0;
        return scaled[2*ANGLE_FRAC-1:ANGLE_FRAC];
    endfunction

    function automatic logic [MAG_W-1:0] top_vote(input logic [MAG_W-1:0] mag,
                                                  input logic [ANGLE_FRAC-1:0] frac);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(mag) * PROD_W'(frac);
        return MAG_W'(prod >> ANGLE_FRAC);
    endfunction

    logic                vld_p0, vld_p1, vld_p2, vld_p3;
    logic [3:0]          bot_p0, bot_p1, bot_p2, bot_p3;
    logic [3:0]          top_p0, top_p1, top_p2, top_p3;
    logic [10:0]         angle_p0;
    logic [MAG_W-1:0]    mag_p0, mag_p1, mag_p2;
    logic [SCALED_W-1:0] scaled_p1;
    logic [MAG_W-1:0]    v_top_p2, v_top_p3, v_bot_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0;
            bot_p0 <= '0; bot_p1 <= '0; bot_p2 <= '0; bot_p3 <= '0;
            top_p0 <= '0; top_p1 <= '0; top_p2 <= '0; top_p3 <= '0;
            angle_p0 <= '0;
            mag_p0 <= '0; mag_p1 <= '0; mag_p2 <= '0;
            scaled_p1 <= '0;
            v_top_p2 <= '0; v_top_p3 <= '0; v_bot_p3 <= '0;
        end else begin
            // p0: input capture
            vld_p0   <= de;
            bot_p0   <= bottom_bin;
            top_p0   <= top_bin;
            angle_p0 <= angle;
            mag_p0   <= magnitude;
            // p1: angle scaled to bin units, u_4_18
            vld_p1    <= vld_p0;
            bot_p1    <= bot_p0;
            top_p1    <= top_p0;
            mag_p1    <= mag_p0;
            scaled_p1 <= SCALED_W'(angle_p0) * SCALED_W'(BIN_SCALE);
            // p2: top vote, truncated
            vld_p2   <= vld_p1;
            bot_p2   <= bot_p1;
            top_p2   <= top_p1;
            mag_p2   <= mag_p1;
            v_top_p2 <= top_vote(mag_p1, interp_frac(scaled_p1));
            // p3: bottom vote is the remainder so the pair always sums to the magnitude
            vld_p3   <= vld_p2;
            bot_p3   <= bot_p2;
            top_p3   <= top_p2;
            v_top_p3 <= v_top_p2;
            v_bot_p3 <= mag_p2 - v_top_p2;
        end
    end

    assign vote_vld        = vld_p3;
    assign vote_bottom_bin = bot_p3;
    assign vote_top_bin    = top_p3;
    assign v_bot           = v_bot_p3;
    assign v_top           = v_top_p3;

endmodule

// File: rtl/hog_cell_vote_accumulator.sv
// Accumulates interpolated orientation votes over horizontal cell segments of
// CELL_W pixels and emits one 9-bin partial histogram per segment.
module hog_cell_vote_accumulator
    import hog_cell_vote_accumulator_pkg::*;
#(
    parameter int MAG_W  = 12,
    parameter int CELL_W = 8,
    parameter int ACC_W  = MAG_W + $clog2(CELL_W)
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      de,
    input  logic [3:0]                bottomBin,
    input  logic [3:0]                topBin,
    input  logic [10:0]               angle0_180,
    input  logic [MAG_W-1:0]          magnitude,
    output logic                      histValid,
    output logic                      histPartial,
    output logic [7:0]                cellIndex,
    output logic [NUM_BINS*ACC_W-1:0] histOut
);

    localparam int CNT_W = $clog2(CELL_W);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             vld_p3, vld_p4;
    logic [3:0]       bot_p3, top_p3;
    logic [MAG_W-1:0] v_bot_p3, v_top_p3;

    hog_cell_vote_accumulator_vote_split #(
        .MAG_W(MAG_W)
    ) vote_split (
        .clk            (pclk),
        .rst            (reset),
        .de             (de),
        .bottom_bin     (bottomBin),
        .top_bin        (topBin),
        .angle          (angle0_180),
        .magnitude      (magnitude),
        .vote_vld       (vld_p3),
        .vote_bottom_bin(bot_p3),
        .vote_top_bin   (top_p3),
        .v_bot          (v_bot_p3),
        .v_top          (v_top_p3)
    );

    seg_state_t       state, state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       seg_idx;
    logic [ACC_W-1:0] acc     [NUM_BINS];
    logic [ACC_W-1:0] acc_sum [NUM_BINS];
    logic             de_fall, full_close, partial_close;

    always_comb begin
        de_fall       = vld_p4 & ~vld_p3;
        full_close    = vld_p3 && (pix_cnt == CNT_W'(CELL_W - 1));
        partial_close = de_fall && (state == ACCUM);
        for (int b = 0; b < NUM_BINS; b++) begin
            acc_sum[b] = acc[b]
                       + ((bot_p3 == 4'(b)) ? ACC_W'(v_bot_p3) : '0)
                       + ((top_p3 == 4'(b)) ? ACC_W'(v_top_p3) : '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vld_p3 && !full_close) state_next = ACCUM;
            ACCUM:   if (full_close || partial_close) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // p4: accumulate, close segments, register the emitted histogram
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            vld_p4      <= 1'b0;
            pix_cnt     <= '0;
            seg_idx     <= '0;
            histValid   <= 1'b0;
            histPartial <= 1'b0;
            cellIndex   <= '0;
            histOut     <= '0;
            for (int b = 0; b < NUM_BINS; b++) acc[b] <= '0;
        end else begin
            state       <= state_next;
            vld_p4      <= vld_p3;
            histValid   <= 1'b0;
            histPartial <= 1'b0;
            if (full_close) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    histOut[b*ACC_W +: ACC_W] <= acc_sum[b];
                    acc[b] <= '0;
                end
                histValid <= 1'b1;
                cellIndex <= seg_idx;
                seg_idx   <= sat_inc(seg_idx);
                pix_cnt   <= '0;
            end else if (partial_close) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    histOut[b*ACC_W +: ACC_W] <= acc[b];
                    acc[b] <= '0;
                end
                histValid   <= 1'b1;
                histPartial <= 1'b1;
                cellIndex   <= seg_idx;
                pix_cnt     <= '0;
            end else if (vld_p3) begin
                for (int b = 0; b < NUM_BINS; b++) acc[b] <= acc_sum[b];
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
            // A line end restarts segment numbering, even after a full close.
            if (de_fall) seg_idx <= '0;
        end
    end

endmodule

// File: tb/tb_hog_cell_vote_accumulator.sv
// Scoreboard bench: a line-level model predicts each histogram strobe and its
// cycle; a monitor checks every DUT strobe against the queued prediction.
module tb_hog_cell_vote_accumulator;

    localparam int MAG_W  = 12;
    localparam int CELL_W = 8;
    localparam int ACC_W  = MAG_W + $clog2(CELL_W);
    localparam int NB     = 9;
    localparam int HW     = NB * ACC_W;

    logic          pclk = 1'b0;
    logic          reset;
    logic          de;
    logic [3:0]    bottomBin, topBin;
    logic [10:0]   angle0_180;
    logic [MAG_W-1:0] magnitude;
    logic          histValid, histPartial;
    logic [7:0]    cellIndex;
    logic [HW-1:0] histOut;

    hog_cell_vote_accumulator #(.MAG_W(MAG_W), .CELL_W(CELL_W)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .de         (de),
        .bottomBin  (bottomBin),
        .topBin     (topBin),
        .angle0_180 (angle0_180),
        .magnitude  (magnitude),
        .histValid  (histValid),
        .histPartial(histPartial),
        .cellIndex  (cellIndex),
        .histOut    (histOut)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [HW-1:0] hist;
        logic          partial;
        logic [7:0]    idx;
        int            due;
    } strobe_t;

    strobe_t sbq[$];
    strobe_t got_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [HW-1:0] last_hist = '0;

    // Line-level reference state
    int m_acc[NB];
    int m_cnt = 0;
    int m_idx = 0;
    bit m_prev_de = 0;

    function automatic int bin_of(logic [HW-1:0] h, int b);
        return int'(h[b*ACC_W +: ACC_W]);
    endfunction

    task automatic push_expected(bit partial);
        strobe_t e;
        for (int b = 0; b < NB; b++) e.hist[b*ACC_W +: ACC_W] = ACC_W'(m_acc[b]);
        e.partial = partial;
        e.idx     = 8'(m_idx);
        e.due     = cyc + 5;
        sbq.push_back(e);
        for (int b = 0; b < NB; b++) m_acc[b] = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(bit d, int bb, int tb, int ang, int mag);
        int scaled, whole, frac, vtop;
        if (d) begin
            scaled = ang * 1467;
            whole  = scaled / 262144;
            frac   = (whole == 9) ? 0 : (scaled / 512) % 512;
            vtop   = (mag * frac) / 512;
            m_acc[bb] += mag - vtop;
            m_acc[tb] += vtop;
            m_cnt++;
            if (m_cnt == CELL_W) begin
                push_expected(1'b0);
                m_idx = (m_idx == 255) ? 255 : m_idx + 1;
            end
        end else if (m_prev_de) begin
            if (m_cnt > 0) push_expected(1'b1);
            m_idx = 0;
        end
        m_prev_de = d;
    endtask

    task automatic drive(bit d, int bb, int tb, int ang, int mag);
        @(posedge pclk); #1;
        de         = d;
        bottomBin  = 4'(bb);
        topBin     = 4'(tb);
        angle0_180 = 11'(ang);
        magnitude  = MAG_W'(mag);
        model_step(d, bb, tb, ang, mag);
    endtask

    task automatic pixels(int n, int bb, int tb, int ang, int mag);
        for (int i = 0; i < n; i++) drive(1'b1, bb, tb, ang, mag);
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0);
    endtask

    task automatic rand_pixel();
        int b, m;
        b = $urandom_range(0, 8);
        case ($urandom_range(0, 7))
            0:       m = 0;
            1:       m = (1 << MAG_W) - 1;
            default: m = $urandom_range(0, (1 << MAG_W) - 1);
        endcase
        drive(1'b1, b, (b + 1) % 9, $urandom_range(0, 1608), m);
    endtask

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() > 0; i++) @(posedge pclk);
        @(negedge pclk);
        check("drain_timeout_pending", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_histValid"}, int'(histValid), 0);
        check({tag, "_histPartial"}, int'(histPartial), 0);
        check({tag, "_cellIndex"}, int'(cellIndex), 0);
        check({tag, "_histOut_nonzero"}, int'(histOut != '0), 0);
    endtask

    task automatic mid_reset();
        @(posedge pclk); #3;
        reset = 1'b1;
        de    = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sbq.delete();
        for (int b = 0; b < NB; b++) m_acc[b] = 0;
        m_cnt = 0; m_idx = 0; m_prev_de = 0;
        last_hist = '0;
        @(posedge pclk); @(posedge pclk); #1;
        reset = 1'b0;
    endtask

    always @(negedge pclk) begin
        strobe_t e;
        if (!reset) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                check("strobe_missing_at_cycle", cyc, e.due);
            end
            if (histValid) begin
                got_q.push_back('{hist: histOut, partial: histPartial, idx: cellIndex, due: cyc});
                if (sbq.size() == 0) begin
                    check("unexpected_strobe_count", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("strobe_cycle", cyc, e.due);
                    for (int b = 0; b < NB; b++)
                        if (bin_of(histOut, b) != bin_of(e.hist, b))
                            $display("  bin %0d: got %0d, expected %0d", b, bin_of(histOut, b), bin_of(e.hist, b));
                    check("histOut_match", int'(histOut == e.hist), 1);
                    check("histPartial", int'(histPartial), int'(e.partial));
                    check("cellIndex", int'(cellIndex), int'(e.idx));
                    last_hist = e.hist;
                end
            end else begin
                check("histOut_hold", int'(histOut == last_hist), 1);
            end
        end
    end

    initial begin
        for (int b = 0; b < NB; b++) m_acc[b] = 0;
        reset = 1'b1; de = 1'b0; bottomBin = '0; topBin = '0;
        angle0_180 = '0; magnitude = '0;
        #12;
        check_reset_outputs("power_on_reset");
        @(posedge pclk); #1;
        reset = 1'b0;

        // Uniform angle: all weight on the bottom bin
        got_q.delete();
        pixels(8, 0, 1, 0, 100); gap(2); drain();
        check("uniform_strobes", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("uniform_bin0", bin_of(got_q[0].hist, 0), 800);
            check("uniform_bin1", bin_of(got_q[0].hist, 1), 0);
            check("uniform_partial", int'(got_q[0].partial), 0);
        end

        // Mid-bin split
        got_q.delete();
        pixels(8, 0, 1, 90, 512); gap(2); drain();
        if (got_q.size() >= 1) begin
            check("midbin_bin0", bin_of(got_q[0].hist, 0), 2040);
            check("midbin_bin1", bin_of(got_q[0].hist, 1), 2056);
        end else check("midbin_strobes", got_q.size(), 1);

        // Wrap from bin 8 to bin 0, single-pixel partial segment
        got_q.delete();
        pixels(1, 8, 0, 1520, 512); gap(2); drain();
        if (got_q.size() >= 1) begin
            check("wrap_bin8", bin_of(got_q[0].hist, 8), 253);
            check("wrap_bin0", bin_of(got_q[0].hist, 0), 259);
            check("wrap_partial", int'(got_q[0].partial), 1);
        end else check("wrap_strobes", got_q.size(), 1);

        // Line ending mid-segment
        got_q.delete();
        pixels(11, 0, 1, 0, 10); gap(2); drain();
        check("partial_line_strobes", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("partial_line_first_bin0", bin_of(got_q[0].hist, 0), 80);
            check("partial_line_first_idx", int'(got_q[0].idx), 0);
            check("partial_line_second_bin0", bin_of(got_q[1].hist, 0), 30);
            check("partial_line_second_partial", int'(got_q[1].partial), 1);
            check("partial_line_second_idx", int'(got_q[1].idx), 1);
        end

        // Back-to-back lines separated by one idle cycle
        got_q.delete();
        pixels(8, 2, 3, 500, 300); gap(1); pixels(8, 4, 5, 900, 77); gap(2); drain();
        check("b2b_strobes", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("b2b_second_idx", int'(got_q[1].idx), 0);
            check("b2b_second_partial", int'(got_q[1].partial), 0);
        end

        // Reset in the middle of a segment discards it
        got_q.delete();
        pixels(5, 0, 1, 300, 1000);
        mid_reset();
        pixels(8, 6, 7, 1234, 4095); gap(2); drain();
        check("post_reset_strobes", got_q.size(), 1);
        if (got_q.size() >= 1) check("post_reset_idx", int'(got_q[0].idx), 0);

        // Randomized lines with varied lengths and gaps
        for (int line = 0; line < 25; line++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int p = 0; p < len; p++) rand_pixel();
            gap($urandom_range(1, 3));
        end
        drain();

        // Long line to push cellIndex into saturation
        got_q.delete();
        for (int p = 0; p < 258 * CELL_W + 3; p++) rand_pixel();
        gap(2); drain();
        if (got_q.size() >= 2)
            check("saturated_idx", int'(got_q[got_q.size() - 2].idx), 255);
        else
            check("long_line_strobes", got_q.size(), 259);

        repeat (4) @(posedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
